mem_access_ctrl: RTL and testbench

//  Bus controller between the ARC core's datapath/control unit and main_memory.
//  It accepts one word read or write per request over a ready/done handshake and drives the memory's rd/wr strobes.
//  It absorbs the memory's one-cycle registered read latency plus optional extra wait states.
//  It blocks writes into the reserved system region.

---
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Word bus controller between the core and main_memory (rd/wr strobes, wait states).
// Optional MEM_ALIGN_CHECK_EN: rejects accesses with addr[1:0] != 0.
module mem_access_ctrl #(
  parameter int WAIT_STATES = 0,
  parameter int USER_BASE   = 2048,
  parameter bit PROTECT_SYS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_data_out
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("WAIT_STATES must be within 0..15");
  end

  localparam logic [31:0] UB_W = 32'(USER_BASE);
  localparam logic [3:0]  WS_W = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sys_rej;
  logic        rej;

  assign sys_rej = PROTECT_SYS && cpu_we && (cpu_addr < UB_W);

`ifdef MEM_ALIGN_CHECK_EN
  assign rej = sys_rej || (cpu_addr[1:0] != 2'b00);
`else
  assign rej = sys_rej;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = rej;
          state_d = rej ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WS_W) begin
          // memory output is registered, valid from the cycle after the strobe
          if (!we_q) rdata_d = mem_data_out;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_ready   = (state_q == S_IDLE);
  assign cpu_done    = (state_q == S_RESP);
  assign cpu_err     = (state_q == S_RESP) && err_q;
  assign cpu_rdata   = rdata_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_rd      = (state_q == S_ACCESS) && !we_q;
  assign mem_wr      = (state_q == S_ACCESS) && we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (0 and 3 wait states)
// each attached to a small registered-read memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance 0: WAIT_STATES = 0
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        rdy0, done0, err0, rd0, wr0;
  logic [31:0] rdata0, maddr0, mdin0, mdout0;

  // instance 1: WAIT_STATES = 3
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        rdy1, done1, err1, rd1, wr1;
  logic [31:0] rdata1, maddr1, mdin1, mdout1;

  mem_access_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req0), .cpu_we(we0),
    .cpu_addr(addr0), .cpu_wdata(wdata0),
    .cpu_ready(rdy0), .cpu_done(done0),
    .cpu_err(err0), .cpu_rdata(rdata0),
    .mem_address(maddr0), .mem_data_in(mdin0),
    .mem_rd(rd0), .mem_wr(wr0),
    .mem_data_out(mdout0)
  );

  mem_access_ctrl #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req1), .cpu_we(we1),
    .cpu_addr(addr1), .cpu_wdata(wdata1),
    .cpu_ready(rdy1), .cpu_done(done1),
    .cpu_err(err1), .cpu_rdata(rdata1),
    .mem_address(maddr1), .mem_data_in(mdin1),
    .mem_rd(rd1), .mem_wr(wr1),
    .mem_data_out(mdout1)
  );

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'd0;
      mem1[i] = 32'd0;
    end
    mem0[0]   = 32'h81C02800;
    mem0[523] = 32'h00000014;
    mem1[523] = 32'h00000014;
  end

  always @(posedge clk) begin
    if (wr0) mem0[maddr0[11:2]] <= mdin0;
    if (rd0) mdout0 <= mem0[maddr0[11:2]];
    if (wr1) mem1[maddr1[11:2]] <= mdin1;
    if (rd1) mdout1 <= mem1[maddr1[11:2]];
  end

  // one access on instance 0; cycle numbers relative to the accept edge
  task automatic access0(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          done_cyc,
    output int          stb_cyc,
    output int          nrd,
    output int          nwr,
    output logic        err,
    output logic [31:0] sa,
    output logic [31:0] sd
  );
    int guard;
    done_cyc = -1;
    stb_cyc  = -1;
    nrd = 0;
    nwr = 0;
    err = 1'bx;
    sa  = 'x;
    sd  = 'x;
    guard = 0;
    @(negedge clk);
    while (!rdy0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req0 = 1'b1;
    we0 = we;
    addr0 = a;
    wdata0 = d;
    @(posedge clk);
    #1 req0 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rd0 || wr0) begin
        stb_cyc = c;
        sa = maddr0;
        sd = mdin0;
      end
      if (rd0) nrd++;
      if (wr0) nwr++;
      if (done0) begin
        done_cyc = c;
        err = err0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy0, done0, err0, rd0, wr0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 10000",
               {rdy0, done0, err0, rd0, wr0});
    end
    n_cmp++;
    if ({rdata0, maddr0, mdin0} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h want 0",
               rdata0, maddr0, mdin0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_read;
    int dc, sc, nr, nw;
    logic e;
    logic [31:0] sa, sd;
    access0(1'b0, 32'd2092, 32'd0, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (sc !== 1 || nr !== 1 || nw !== 0) begin
      n_bad++;
      $display("FAIL read_strobe got cyc=%0d rd=%0d wr=%0d want 1/1/0",
               sc, nr, nw);
    end
    n_cmp++;
    if (sa !== 32'd2092) begin
      n_bad++;
      $display("FAIL read_addr got %0d want 2092", sa);
    end
    n_cmp++;
    if (dc !== 3 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL read_done got cyc=%0d err=%b want 3/0", dc, e);
    end
    n_cmp++;
    if (rdata0 !== 32'h00000014) begin
      n_bad++;
      $display("FAIL read_data got %h want 00000014", rdata0);
    end
  endtask

  task automatic test_write_read;
    int dc, sc, nr, nw;
    logic e;
    logic [31:0] sa, sd;
    access0(1'b1, 32'd2100, 32'hDEADBEEF, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (nw !== 1 || nr !== 0 || sc !== 1) begin
      n_bad++;
      $display("FAIL write_strobe got wr=%0d rd=%0d cyc=%0d want 1/0/1",
               nw, nr, sc);
    end
    n_cmp++;
    if (sd !== 32'hDEADBEEF || sa !== 32'd2100) begin
      n_bad++;
      $display("FAIL write_bus got %h@%0d want deadbeef@2100", sd, sa);
    end
    n_cmp++;
    if (dc !== 3 || e !== 1'b0 || rdata0 !== 32'h00000014) begin
      n_bad++;
      $display("FAIL write_done got cyc=%0d err=%b rdata=%h want 3/0/14",
               dc, e, rdata0);
    end
    access0(1'b0, 32'd2100, 32'd0, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (rdata0 !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++;
      $display("FAIL readback got %h err=%b want deadbeef/0", rdata0, e);
    end
  endtask

  task automatic test_protect;
    int dc, sc, nr, nw;
    logic e;
    logic [31:0] sa, sd;
    access0(1'b1, 32'd4, 32'h1, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (nw !== 0 || nr !== 0 || dc !== 1 || e !== 1'b1) begin
      n_bad++;
      $display("FAIL prot_wr got wr=%0d rd=%0d cyc=%0d err=%b want 0/0/1/1",
               nw, nr, dc, e);
    end
    n_cmp++;
    if (rdata0 !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL prot_rdata got %h want deadbeef", rdata0);
    end
    access0(1'b1, 32'd2044, 32'h2, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (nw !== 0 || e !== 1'b1) begin
      n_bad++;
      $display("FAIL prot_edge_lo got wr=%0d err=%b want 0/1", nw, e);
    end
    access0(1'b1, 32'd2048, 32'h55, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (nw !== 1 || e !== 1'b0 || dc !== 3) begin
      n_bad++;
      $display("FAIL prot_edge_base got wr=%0d err=%b cyc=%0d want 1/0/3",
               nw, e, dc);
    end
    access0(1'b0, 32'd0, 32'd0, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (rdata0 !== 32'h81C02800 || e !== 1'b0 || nr !== 1) begin
      n_bad++;
      $display("FAIL boot_read got %h err=%b rd=%0d want 81c02800/0/1",
               rdata0, e, nr);
    end
    access0(1'b0, 32'd2048, 32'd0, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (rdata0 !== 32'h00000055) begin
      n_bad++;
      $display("FAIL base_read got %h want 00000055", rdata0);
    end
  endtask

  task automatic test_align;
    int dc, sc, nr, nw;
    logic e;
    logic [31:0] sa, sd;
    access0(1'b0, 32'd2094, 32'd0, dc, sc, nr, nw, e, sa, sd);
`ifdef MEM_ALIGN_CHECK_EN
    n_cmp++;
    if (nr !== 0 || e !== 1'b1 || dc !== 1) begin
      n_bad++;
      $display("FAIL align got rd=%0d err=%b cyc=%0d want 0/1/1",
               nr, e, dc);
    end
    n_cmp++;
    if (rdata0 !== 32'h00000055) begin
      n_bad++;
      $display("FAIL align_rdata got %h want 00000055", rdata0);
    end
`else
    n_cmp++;
    if (nr !== 1 || e !== 1'b0 || sa !== 32'd2094) begin
      n_bad++;
      $display("FAIL align got rd=%0d err=%b addr=%0d want 1/0/2094",
               nr, e, sa);
    end
    n_cmp++;
    if (rdata0 !== 32'h00000014) begin
      n_bad++;
      $display("FAIL align_rdata got %h want 00000014", rdata0);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int done_a, done_b, stb_a, stb_b, nstb, rdy_c;
    done_a = -1;
    done_b = -1;
    stb_a = -1;
    stb_b = -1;
    rdy_c = -1;
    nstb = 0;
    @(negedge clk);
    req1 = 1'b1;
    we1 = 1'b0;
    addr1 = 32'd2092;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rd1 || wr1) begin
        nstb++;
        if (stb_a < 0) stb_a = c;
        else stb_b = c;
      end
      if (rdy1 && rdy_c < 0) rdy_c = c;
      if (done1) begin
        if (done_a < 0) done_a = c;
        else done_b = c;
      end
      if (c == 9) req1 = 1'b0;
    end
    req1 = 1'b0;
    n_cmp++;
    if (done_a !== 6 || stb_a !== 1) begin
      n_bad++;
      $display("FAIL ws3_first got done=%0d stb=%0d want 6/1",
               done_a, stb_a);
    end
    n_cmp++;
    if (rdy_c !== 7 || stb_b !== 8 || done_b !== 13) begin
      n_bad++;
      $display("FAIL ws3_second got rdy=%0d stb=%0d done=%0d want 7/8/13",
               rdy_c, stb_b, done_b);
    end
    n_cmp++;
    if (nstb !== 2 || rdata1 !== 32'h00000014) begin
      n_bad++;
      $display("FAIL ws3_count got strobes=%0d rdata=%h want 2/14",
               nstb, rdata1);
    end
  endtask

  task automatic test_reset_mid;
    int dc, sc, nr, nw, seen;
    logic e;
    logic [31:0] sa, sd;
    @(negedge clk);
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 32'd2100;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd0 !== 1'b0 || wr0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid got rd=%b wr=%b rdy=%b want 0/0/1",
               rd0, wr0, rdy0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || rdata0 !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_after got dones=%0d rdata=%h want 0/0",
               seen, rdata0);
    end
    access0(1'b0, 32'd2092, 32'd0, dc, sc, nr, nw, e, sa, sd);
    n_cmp++;
    if (dc !== 3 || rdata0 !== 32'h00000014 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_recover got cyc=%0d rdata=%h err=%b want 3/14/0",
               dc, rdata0, e);
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_read;
    test_protect;
    test_align;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
